// File: rtl/usb_aes_pkg.sv
// Shared types and pad helper for the receive-FIFO to AES block packer.
package usb_aes_pkg;

  typedef enum logic [1:0] {FILL, HOLD, EXTRA} state_e;

  localparam int PAD_ZERO  = 0;
  localparam int PAD_PKCS7 = 1;

  // Pad value for the bytes after index idx of a final partial block.
  function automatic logic [7:0] pad_byte(input int mode, input int idx, input int bytes);
    if (mode == PAD_ZERO) return 8'h00;
    return 8'(bytes - idx - 1);
  endfunction

endpackage

// File: rtl/usb_block_packer.sv
// Packs received payload bytes into BYTES-wide blocks (first byte in MSBs),
// with zero or PKCS#7 padding of the final block and abort flush.
module usb_block_packer
  import usb_aes_pkg::*;
#(
  parameter int BYTES    = 16,
  parameter int PAD_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic                       pkt_abort,
  output logic [BYTES*8-1:0]         blk_data,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic                       blk_last,
  output logic [$clog2(BYTES+1)-1:0] blk_bytes
);

  localparam int IW = $clog2(BYTES);
  localparam int BW = $clog2(BYTES+1);
  localparam int DW = BYTES*8;
  localparam logic [IW-1:0] IDX_MAX = IW'(BYTES-1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   data_q, data_d;
  logic [BW-1:0]   bytes_q, bytes_d;
  logic            last_q, last_d;
  logic            extra_q, extra_d;
  logic [DW-1:0]   fill_data, extra_data;
  logic [7:0]      pad_val;
  logic            need_extra;

  assign pad_val    = pad_byte(PAD_MODE, int'(idx_q), BYTES);
  // A PKCS#7 packet ending exactly on a block boundary needs a whole pad block.
  assign need_extra = (PAD_MODE == PAD_PKCS7) && (idx_q == IDX_MAX);

  for (genvar k = 0; k < BYTES; k++) begin : g_lane
    localparam int HI = DW-1-8*k;
    assign fill_data[HI -: 8]  = (idx_q == IW'(k))                 ? in_data :
                                 (in_last && (IW'(k) > idx_q))     ? pad_val :
                                                                     data_q[HI -: 8];
    assign extra_data[HI -: 8] = 8'(BYTES);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    bytes_d = bytes_q;
    last_d  = last_q;
    extra_d = extra_q;
    if (pkt_abort) begin
      state_d = FILL;
      idx_d   = '0;
      data_d  = '0;
      bytes_d = '0;
      last_d  = 1'b0;
      extra_d = 1'b0;
    end else begin
      case (state_q)
        FILL: if (in_valid) begin
          data_d = fill_data;
          if (in_last) begin
            state_d = HOLD;
            idx_d   = '0;
            bytes_d = BW'(idx_q) + BW'(1);
            last_d  = !need_extra;
            extra_d = need_extra;
          end else if (idx_q == IDX_MAX) begin
            state_d = HOLD;
            idx_d   = '0;
            bytes_d = BW'(BYTES);
            last_d  = 1'b0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        HOLD: if (blk_ready) begin
          if (extra_q) begin
            state_d = EXTRA;
            extra_d = 1'b0;
          end else begin
            state_d = FILL;
          end
        end
        EXTRA: begin
          data_d  = extra_data;
          bytes_d = '0;
          last_d  = 1'b1;
          state_d = HOLD;
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
      bytes_q <= '0;
      last_q  <= 1'b0;
      extra_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      bytes_q <= bytes_d;
      last_q  <= last_d;
      extra_q <= extra_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q == HOLD);
  assign blk_data  = data_q;
  assign blk_bytes = bytes_q;
  assign blk_last  = last_q;

endmodule

// File: tb/tb_usb_block_packer.sv
// Bench for usb_block_packer: a 16-byte PKCS#7 instance and an 8-byte zero-pad
// instance, checked against a packet-level block model.
module tb_usb_block_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sel;
  logic [7:0] in_data;
  logic       in_valid, in_last, pkt_abort, blk_ready;

  logic         r16, v16, l16;
  logic [127:0] d16;
  logic [4:0]   n16;
  logic         r8, v8, l8;
  logic [63:0]  d8;
  logic [3:0]   n8;

  usb_block_packer #(.BYTES(16), .PAD_MODE(1)) dut16 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid & ~sel),
    .in_last(in_last), .in_ready(r16), .pkt_abort(pkt_abort & ~sel),
    .blk_data(d16), .blk_valid(v16), .blk_ready(blk_ready & ~sel),
    .blk_last(l16), .blk_bytes(n16));

  usb_block_packer #(.BYTES(8), .PAD_MODE(0)) dut8 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid & sel),
    .in_last(in_last), .in_ready(r8), .pkt_abort(pkt_abort & sel),
    .blk_data(d8), .blk_valid(v8), .blk_ready(blk_ready & sel),
    .blk_last(l8), .blk_bytes(n8));

  logic         o_rdy, o_valid, o_last;
  logic [255:0] o_data;
  logic [5:0]   o_nb;
  assign o_rdy   = sel ? r8 : r16;
  assign o_valid = sel ? v8 : v16;
  assign o_last  = sel ? l8 : l16;
  assign o_data  = sel ? {d8, 192'b0} : {d16, 128'b0};
  assign o_nb    = sel ? 6'(n8) : 6'(n16);

  int compared = 0;
  int mismatched = 0;

  logic [255:0] exp_blk[$];
  logic [5:0]   exp_nb[$];
  logic         exp_last[$];

  // Packet-level model: chop into B-byte chunks, pad the last one, and add a
  // full pad block when PKCS#7 meets an exact multiple.
  task automatic build_exp(input logic [7:0] p[$], input int B, input int mode);
    int n;
    logic [255:0] blk;
    bit fin;
    exp_blk.delete(); exp_nb.delete(); exp_last.delete();
    for (int off = 0; off < p.size(); off += B) begin
      n   = (p.size() - off < B) ? p.size() - off : B;
      fin = (off + n == p.size());
      blk = '0;
      for (int j = 0; j < n; j++) blk[255-8*j -: 8] = p[off+j];
      if (fin && n < B)
        for (int j = n; j < B; j++) blk[255-8*j -: 8] = (mode == 1) ? 8'(B-n) : 8'h00;
      exp_blk.push_back(blk);
      exp_nb.push_back(6'(n));
      exp_last.push_back(fin && !(mode == 1 && n == B));
      if (fin && mode == 1 && n == B) begin
        blk = '0;
        for (int j = 0; j < B; j++) blk[255-8*j -: 8] = 8'(B);
        exp_blk.push_back(blk);
        exp_nb.push_back(6'd0);
        exp_last.push_back(1'b1);
      end
    end
  endtask

  // Present bytes one at a time, holding each until accepted. Starts and ends on a negedge.
  task automatic feed(input logic [7:0] p[$], input bit last_flag);
    int guard;
    for (int i = 0; i < p.size(); i++) begin
      in_data  = p[i];
      in_last  = last_flag && (i == p.size()-1);
      in_valid = 1'b1;
      guard = 0;
      while (!o_rdy && guard < 100) begin @(negedge clk); guard++; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_pkt(input string nm, input logic [7:0] p[$], input int vp, input int rp);
    int pi, bi, cyc;
    pi = 0; bi = 0; cyc = 0;
    build_exp(p, sel ? 8 : 16, sel ? 0 : 1);
    while ((pi < p.size() || bi < exp_blk.size()) && cyc < 3000) begin
      in_valid  = (pi < p.size()) && (int'($urandom_range(99)) < vp);
      in_data   = (pi < p.size()) ? p[pi] : 8'h00;
      in_last   = (pi == p.size()-1);
      blk_ready = (int'($urandom_range(99)) < rp);
      if (o_valid && blk_ready) begin
        compared++;
        if (bi >= exp_blk.size()) begin
          mismatched++;
          $display("FAIL %s unexpected block %0d: data=%h", nm, bi, o_data);
        end else if (o_data !== exp_blk[bi] || o_nb !== exp_nb[bi] || o_last !== exp_last[bi]) begin
          mismatched++;
          $display("FAIL %s blk%0d got %h bytes=%0d last=%b want %h bytes=%0d last=%b",
                   nm, bi, o_data, o_nb, o_last, exp_blk[bi], exp_nb[bi], exp_last[bi]);
        end
        bi++;
      end
      if (o_rdy && in_valid) pi++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
    compared++;
    if (cyc >= 3000) begin
      mismatched++;
      $display("FAIL %s timeout: sent %0d/%0d blocks %0d/%0d", nm, pi, p.size(), bi, exp_blk.size());
    end
    repeat (3) @(negedge clk);
    compared++;
    if (o_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL %s trailing block: valid=%b want 0 data=%h", nm, o_valid, o_data);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    pkt_abort = 1'b0; blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    compared++;
    if (r16 !== 1'b1 || v16 !== 1'b0 || l16 !== 1'b0 || n16 !== 5'd0 || d16 !== '0) begin
      mismatched++;
      $display("FAIL reset16 rdy=%b vld=%b last=%b bytes=%0d data=%h want 1 0 0 0 0", r16, v16, l16, n16, d16);
    end
    compared++;
    if (r8 !== 1'b1 || v8 !== 1'b0 || l8 !== 1'b0 || n8 !== 4'd0 || d8 !== '0) begin
      mismatched++;
      $display("FAIL reset8 rdy=%b vld=%b last=%b bytes=%0d data=%h want 1 0 0 0 0", r8, v8, l8, n8, d8);
    end
  endtask

  task automatic test_pkcs_full();
    logic [7:0] p[$];
    sel = 1'b0;
    for (int i = 0; i < 16; i++) p.push_back(8'(i));
    run_pkt("pkcs_full", p, 100, 60);
  endtask

  task automatic test_pkcs_partial();
    logic [7:0] p[$];
    sel = 1'b0;
    for (int i = 0; i < 5; i++) p.push_back(8'(8'hA0 + i));
    feed(p, 1'b1);
    compared++;
    if (v16 !== 1'b1 || d16 !== 128'hA0A1A2A3A40B0B0B0B0B0B0B0B0B0B0B || n16 !== 5'd5 || l16 !== 1'b1) begin
      mismatched++;
      $display("FAIL pkcs_partial vld=%b data=%h bytes=%0d last=%b want 1 A0A1A2A3A40B..0B 5 1", v16, d16, n16, l16);
    end
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    compared++;
    if (v16 !== 1'b0) begin
      mismatched++;
      $display("FAIL pkcs_partial_drop vld=%b want 0", v16);
    end
  endtask

  task automatic test_zero_mode();
    logic [7:0] p[$];
    logic [7:0] q[$];
    sel = 1'b1;
    for (int i = 0; i < 8; i++) p.push_back(8'($urandom));
    run_pkt("zero_exact", p, 80, 70);
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    run_pkt("zero_partial", q, 100, 100);
  endtask

  task automatic test_backpressure();
    logic [7:0] p[$];
    logic [7:0] q[$];
    logic [127:0] snap;
    sel = 1'b0;
    for (int i = 0; i < 10; i++) p.push_back(8'($urandom));
    feed(p, 1'b1);
    build_exp(p, 16, 1);
    compared++;
    if (o_valid !== 1'b1 || o_data !== exp_blk[0] || o_nb !== exp_nb[0] || o_last !== exp_last[0]) begin
      mismatched++;
      $display("FAIL bp_block vld=%b data=%h bytes=%0d last=%b want %h %0d %b",
               o_valid, o_data, o_nb, o_last, exp_blk[0], exp_nb[0], exp_last[0]);
    end
    snap = d16;
    in_data = 8'h77; in_valid = 1'b1; in_last = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      compared++;
      if (d16 !== snap || v16 !== 1'b1 || r16 !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold cyc%0d data=%h vld=%b rdy=%b want %h 1 0", c, d16, v16, r16, snap);
      end
    end
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    q.push_back(8'h77);
    for (int i = 1; i < 16; i++) q.push_back(8'($urandom));
    run_pkt("bp_after", q, 100, 100);
  endtask

  task automatic test_abort();
    logic [7:0] p[$];
    logic [7:0] q[$];
    sel = 1'b0;
    for (int i = 0; i < 7; i++) p.push_back(8'($urandom));
    feed(p, 1'b0);
    in_data = 8'h99; in_valid = 1'b1; pkt_abort = 1'b1;
    @(negedge clk);
    pkt_abort = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      compared++;
      if (v16 !== 1'b0 || r16 !== 1'b1) begin
        mismatched++;
        $display("FAIL abort_idle cyc%0d vld=%b rdy=%b want 0 1", c, v16, r16);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) q.push_back(8'(8'h40 + i));
    run_pkt("abort_next", q, 100, 100);
  endtask

  task automatic test_reset_hold();
    logic [7:0] p[$];
    sel = 1'b0;
    for (int i = 0; i < 16; i++) p.push_back(8'($urandom));
    feed(p, 1'b1);
    compared++;
    if (v16 !== 1'b1 || n16 !== 5'd16 || l16 !== 1'b0) begin
      mismatched++;
      $display("FAIL rh_pre vld=%b bytes=%0d last=%b want 1 16 0", v16, n16, l16);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compared++;
    if (v16 !== 1'b0 || n16 !== 5'd0 || d16 !== '0 || r16 !== 1'b1 || l16 !== 1'b0) begin
      mismatched++;
      $display("FAIL rh_post vld=%b bytes=%0d data=%h rdy=%b last=%b want 0 0 0 1 0", v16, n16, d16, r16, l16);
    end
    blk_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      compared++;
      if (v16 !== 1'b0) begin
        mismatched++;
        $display("FAIL rh_no_extra cyc%0d vld=%b want 0", c, v16);
      end
    end
    blk_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] p[$];
    int len;
    for (int t = 0; t < 12; t++) begin
      sel = 1'($urandom_range(1));
      len = int'($urandom_range(40, 1));
      p.delete();
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      run_pkt($sformatf("random%0d", t), p, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)));
    end
  endtask

  initial begin
    test_reset();
    test_pkcs_full();
    test_pkcs_partial();
    test_zero_mode();
    test_backpressure();
    test_abort();
    test_reset_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
